// File: rtl/clk_gen_param.sv
// Parametrised phase-aligned clock divider with gated outputs,
// rise strobes, resync and lock. Ports: clk_32f, reset, en, resync,
// clk_out, rise_stb, locked.
module clk_gen_param #(
  parameter int TOP_LOG2 = 5,
  parameter int NUM_OUT  = 3
) (
  input  logic               clk_32f,
  input  logic               reset,
  input  logic [NUM_OUT-1:0] en,
  input  logic               resync,
  output logic [NUM_OUT-1:0] clk_out,
  output logic [NUM_OUT-1:0] rise_stb,
  output logic               locked
);

  localparam int W = TOP_LOG2;

  logic [W-1:0]       cnt;
  logic [W-1:0]       cnt_nx;
  logic [W-1:0]       cnt_nx2;
  logic [NUM_OUT-1:0] g;
  logic [NUM_OUT-1:0] g_nx;
  logic [NUM_OUT-1:0] raw_nx;
  logic [NUM_OUT-1:0] raw_nx2;

  // Look one and two counts ahead so every output is a plain flop.
  // A gate only reloads while its next phase is low, which keeps
  // started pulses whole and first pulses full width.
  always_comb begin
    cnt_nx  = cnt + W'(1);
    cnt_nx2 = cnt + W'(2);
    raw_nx  = '0;
    raw_nx2 = '0;
    g_nx    = g;
    for (int i = 0; i < NUM_OUT; i++) begin
      raw_nx[i]  = cnt_nx[W-1-i];
      raw_nx2[i] = cnt_nx2[W-1-i];
      g_nx[i]    = raw_nx[i] ? g[i] : en[i];
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt      <= '0;
      g        <= '0;
      clk_out  <= '0;
      rise_stb <= '0;
      locked   <= 1'b0;
    end else if (resync) begin
      cnt      <= '0;
      clk_out  <= '0;
      rise_stb <= '0;
      locked   <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      g        <= g_nx;
      clk_out  <= raw_nx & g_nx;
      // The gate cannot change across a low-to-high step, so the
      // gate loaded now also governs the rising edge after it.
      rise_stb <= g_nx & ~raw_nx & raw_nx2;
      locked   <= locked | (&cnt);
    end
  end

endmodule

// File: tb/tb_clk_gen_param.sv
// Scoreboard bench for clk_gen_param: default instance (5/3) and
// a 4/4 instance sharing clock, reset and resync.
module tb_clk_gen_param;

  typedef struct packed {
    logic [2:0] ca;
    logic [2:0] sa;
    logic       la;
    logic [3:0] cb;
    logic [3:0] sb;
    logic       lb;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       resync = 1'b0;
  logic [2:0] en = 3'b111;
  logic [2:0] ca, sa;
  logic [3:0] cb, sb;
  logic       la, lb;

  exp_t q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  int         p = 0;
  logic [2:0] ga = '0;
  logic [3:0] gb = '0;
  logic       mla = 1'b0;
  logic       mlb = 1'b0;

  clk_gen_param u_a (
    .clk_32f (clk),
    .reset   (reset),
    .en      (en),
    .resync  (resync),
    .clk_out (ca),
    .rise_stb(sa),
    .locked  (la)
  );

  clk_gen_param #(.TOP_LOG2(4), .NUM_OUT(4)) u_b (
    .clk_32f (clk),
    .reset   (reset),
    .en      (4'hF),
    .resync  (resync),
    .clk_out (cb),
    .rise_stb(sb),
    .locked  (lb)
  );

  initial forever #5 clk = ~clk;

  function automatic bit hi(int top, int i, int ph);
    int per;
    per = top >> i;
    return (ph % per) >= (per / 2);
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Expected outputs after each edge, from the cycle count since
  // the last reset/resync and the en values sampled at that edge.
  task automatic step();
    exp_t e;
    @(posedge clk);
    e = '0;
    if (reset) begin
      p = 0; ga = '0; gb = '0; mla = 0; mlb = 0;
    end else if (resync) begin
      p = 0; mla = 0; mlb = 0;
    end else begin
      p++;
      if (p % 32 == 0) mla = 1;
      if (p % 16 == 0) mlb = 1;
      for (int i = 0; i < 3; i++) begin
        if (!hi(32, i, p)) ga[i] = en[i];
        e.ca[i] = hi(32, i, p) & ga[i];
        e.sa[i] = ga[i] & !hi(32, i, p) & hi(32, i, p + 1);
      end
      for (int i = 0; i < 4; i++) begin
        if (!hi(16, i, p)) gb[i] = 1'b1;
        e.cb[i] = hi(16, i, p) & gb[i];
        e.sb[i] = gb[i] & !hi(16, i, p) & hi(16, i, p + 1);
      end
    end
    e.la = mla;
    e.lb = mlb;
    q.push_back(e);
    #1;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic run_to(int ph);
    for (int k = 0; k < 64 && (p % 32) != ph; k++) step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("clk_out_a", int'(ca), int'(e.ca));
      chk("rise_stb_a", int'(sa), int'(e.sa));
      chk("locked_a", int'(la), int'(e.la));
      chk("clk_out_b", int'(cb), int'(e.cb));
      chk("rise_stb_b", int'(sb), int'(e.sb));
      chk("locked_b", int'(lb), int'(e.lb));
    end
  end

  initial begin
    // reset, free run, lock
    run(3);
    reset = 1'b0;
    run(70);
    // drop en[0] four cycles into a high phase
    run_to(20);
    en[0] = 1'b0;
    run(40);
    // re-enable mid high phase
    run_to(24);
    en[0] = 1'b1;
    run(70);
    // mixed enables
    en = 3'b101;
    run(37);
    en = 3'b000;
    run(29);
    en = 3'b010;
    run(33);
    en = 3'b111;
    run(40);
    // single resync pulse at cnt=21
    run_to(21);
    resync = 1'b1;
    run(1);
    resync = 1'b0;
    run(70);
    // held resync
    run_to(18);
    resync = 1'b1;
    run(5);
    resync = 1'b0;
    run(40);
    // reset with resync, then reset alone at cnt=9
    reset = 1'b1;
    resync = 1'b1;
    run(1);
    reset = 1'b0;
    resync = 1'b0;
    run_to(9);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(70);
    for (int k = 0; k < 5 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
